// File: rtl/pot_pkg.sv
// Shared types for the pot sampler: channel enum, widths, SPI FSM states, command builder.
// Latency: none; this file holds types, constants and pure functions only.
// Backpressure: none.
package pot_pkg;
    localparam int NUM_CH     = 6;
    localparam int FRAME_BITS = 16;
    localparam int POT_W      = 12;

    typedef enum logic [2:0] {
        CH_LP  = 3'd0,
        CH_B1  = 3'd1,
        CH_B2  = 3'd2,
        CH_B3  = 3'd3,
        CH_HP  = 3'd4,
        CH_VOL = 3'd5
    } ch_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PORCH,
        ST_SHIFT,
        ST_BACK
    } spi_state_e;

    // Round-robin successor, wrapping volume back to the low-pass pot.
    function automatic ch_e next_ch(input ch_e c);
        return (c == CH_VOL) ? CH_LP : ch_e'(c + 3'd1);
    endfunction

    // ADC command word: two leading zeros, channel, then don't-care zeros.
    function automatic logic [FRAME_BITS-1:0] adc_cmd(input ch_e c);
        return {2'b00, c, 11'b0};
    endfunction
endpackage

// File: rtl/spi_mstr16.sv
// One 16-bit SPI mode-0 transaction: porch, 16 SCLK periods, back porch, then done.
// Latency: 34*SCLK_HALF clks from start to done; resp valid while done is high.
// Backpressure: start is ignored while busy; done is a single-clk pulse with no handshake.
module spi_mstr16 import pot_pkg::*; #(
    parameter int SCLK_HALF = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] cmd,
    input  logic                  miso,
    output logic                  ss_n,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] resp
);
    localparam int L  = $clog2(SCLK_HALF);
    localparam int CW = L + 5;   // counts 32 half periods of SCLK
    localparam logic [CW-1:0] HALF_END = CW'(SCLK_HALF - 1);

    spi_state_e            state_q, state_nxt;
    logic [CW-1:0]         cnt_q, cnt_nxt, cnt_inc;
    logic                  ss_n_q, ss_n_nxt;
    logic                  sclk_q, sclk_nxt;
    logic                  mosi_q, mosi_nxt;
    logic [FRAME_BITS-1:0] tx_q, tx_nxt;
    logic [FRAME_BITS-1:0] rx_q, rx_nxt;

    assign cnt_inc = cnt_q + CW'(1);

    // Next-state and next-output decode; pins are registered so they never glitch.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        ss_n_nxt  = ss_n_q;
        sclk_nxt  = sclk_q;
        mosi_nxt  = mosi_q;
        tx_nxt    = tx_q;
        rx_nxt    = rx_q;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_PORCH;
                    cnt_nxt   = '0;
                    ss_n_nxt  = 1'b0;
                    sclk_nxt  = 1'b0;
                    mosi_nxt  = cmd[FRAME_BITS-1];          // MSB valid as SS_n falls
                    tx_nxt    = {cmd[FRAME_BITS-2:0], 1'b0};
                end
            end
            ST_PORCH: begin
                if (cnt_q == HALF_END) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_SHIFT: begin
                cnt_nxt = cnt_inc;
                // Every SCLK_HALF clks the clock toggles; odd half periods are high.
                if (cnt_inc[L-1:0] == '0) begin
                    if (cnt_inc[L]) begin
                        sclk_nxt = 1'b1;
                        rx_nxt   = {rx_q[FRAME_BITS-2:0], miso};
                    end else begin
                        sclk_nxt = 1'b0;
                        mosi_nxt = tx_q[FRAME_BITS-1];
                        tx_nxt   = {tx_q[FRAME_BITS-2:0], 1'b0};
                    end
                end
                if (cnt_q == '1) begin
                    state_nxt = ST_BACK;
                    cnt_nxt   = '0;
                end
            end
            ST_BACK: begin
                if (cnt_q == HALF_END) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    ss_n_nxt  = 1'b1;
                    mosi_nxt  = 1'b0;
                    done      = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and pin registers; reset drops any frame in flight immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ss_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            ss_n_q  <= ss_n_nxt;
            sclk_q  <= sclk_nxt;
            mosi_q  <= mosi_nxt;
            tx_q    <= tx_nxt;
            rx_q    <= rx_nxt;
        end
    end

    assign ss_n = ss_n_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign busy = (state_q != ST_IDLE);
    assign resp = rx_q;
endmodule

// File: rtl/pot_sampler.sv
// Round-robin sampler of six pots through a 16-bit SPI ADC into registered pot outputs.
// Latency: one frame (GAP + 34*SCLK_HALF clks) per channel; data lands one frame after its request.
// Backpressure: none; pot_upd pulses one clk per write. POT_FILTER_EN enables 2-tap averaging.
module pot_sampler import pot_pkg::*; #(
    parameter int SCLK_HALF = 16,
    parameter int GAP       = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             SS_n,
    output logic             SCLK,
    output logic             MOSI,
    input  logic             MISO,
    output logic [POT_W-1:0] lp_pot,
    output logic [POT_W-1:0] b1_pot,
    output logic [POT_W-1:0] b2_pot,
    output logic [POT_W-1:0] b3_pot,
    output logic [POT_W-1:0] hp_pot,
    output logic [POT_W-1:0] volume,
    output logic             pot_upd,
    output logic [2:0]       pot_ch
);
    localparam int GW = $clog2(GAP + 1);

    logic [GW-1:0]         gap_q;
    logic                  start, busy, done;
    logic [FRAME_BITS-1:0] resp;
    logic [3:0]            resp_unused;
    logic [POT_W-1:0]      new_val, wr_val;
    ch_e                   ch_q, prev_q;
    logic                  discard_q;
    logic                  pot_upd_q;
    logic [2:0]            pot_ch_q;
    logic [POT_W-1:0]      pot_q [NUM_CH];

    assign start       = !busy && (gap_q == GW'(GAP - 1));
    assign new_val     = resp[POT_W-1:0];
    assign resp_unused = resp[FRAME_BITS-1:POT_W];   // ADC pads the top nibble

    spi_mstr16 #(.SCLK_HALF(SCLK_HALF)) u_spi (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .cmd   (adc_cmd(ch_q)),
        .miso  (MISO),
        .ss_n  (SS_n),
        .sclk  (SCLK),
        .mosi  (MOSI),
        .busy  (busy),
        .done  (done),
        .resp  (resp)
    );

    // Counts SS_n-high clks between frames; restarts whenever a frame runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q <= '0;
        end else if (busy || start) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_q + GW'(1);
        end
    end

`ifdef POT_FILTER_EN
    logic [NUM_CH-1:0] primed_q;
    logic [POT_W:0]    avg_sum;

    // Average of stored and fresh sample, rounded up; first sample per channel loads raw.
    always_comb begin
        avg_sum = {1'b0, pot_q[prev_q]} + {1'b0, new_val} + {{POT_W{1'b0}}, 1'b1};
        wr_val  = primed_q[prev_q] ? POT_W'(avg_sum >> 1) : new_val;
    end

    // Remembers which channels already hold a real sample since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            primed_q <= '0;
        end else if (done && !discard_q) begin
            primed_q[prev_q] <= 1'b1;
        end
    end
`else
    assign wr_val = new_val;
`endif

    // Channel sequencing and pot write-back when each frame completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) pot_q[i] <= '0;
            ch_q      <= CH_LP;
            prev_q    <= CH_LP;
            discard_q <= 1'b1;
            pot_upd_q <= 1'b0;
            pot_ch_q  <= 3'd0;
        end else begin
            pot_upd_q <= 1'b0;
            if (done) begin
                prev_q <= ch_q;
                ch_q   <= next_ch(ch_q);
                // The first frame's response belongs to no requested channel.
                if (discard_q) begin
                    discard_q <= 1'b0;
                end else begin
                    pot_q[prev_q] <= wr_val;
                    pot_upd_q     <= 1'b1;
                    pot_ch_q      <= prev_q;
                end
            end
        end
    end

    assign lp_pot  = pot_q[CH_LP];
    assign b1_pot  = pot_q[CH_B1];
    assign b2_pot  = pot_q[CH_B2];
    assign b3_pot  = pot_q[CH_B3];
    assign hp_pot  = pot_q[CH_HP];
    assign volume  = pot_q[CH_VOL];
    assign pot_upd = pot_upd_q;
    assign pot_ch  = pot_ch_q;
endmodule

// File: tb/tb_pot_sampler.sv
// Bench for pot_sampler: SPI ADC model plus a per-channel expected-pot model.
// Latency: frames of GAP + 34*SH clks; updates expected two frames after reset, then one per frame.
// Backpressure: none; the bench only observes pot_upd pulses.
module tb_pot_sampler;
    localparam int SH    = 16;
    localparam int GAP   = 16;
    localparam int FRAME = GAP + 34 * SH;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MISO = 1'b0;
    logic        SS_n, SCLK, MOSI, pot_upd;
    logic [11:0] lp_pot, b1_pot, b2_pot, b3_pot, hp_pot, volume;
    logic [2:0]  pot_ch;

    int compared = 0;
    int mismatched = 0;

    pot_sampler #(.SCLK_HALF(SH), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .lp_pot(lp_pot), .b1_pot(b1_pot), .b2_pot(b2_pot), .b3_pot(b3_pot),
        .hp_pot(hp_pot), .volume(volume), .pot_upd(pot_upd), .pot_ch(pot_ch)
    );

    always #5 clk = ~clk;

    // ADC model: answers each frame with the channel decoded in the previous full frame.
    logic [11:0] adc_val [6];
    logic [3:0]  adc_nib = 4'h0;
    logic [15:0] adc_tx = '0, adc_rx = '0;
    int          adc_bits = 0;
    logic [2:0]  adc_last_ch = 3'd0;
    logic        ss_prev = 1'b1, sclk_prev = 1'b0;
    logic [15:0] mosi_words [$];

    always @(SS_n or SCLK) begin
        if (ss_prev === 1'b1 && SS_n === 1'b0) begin
            adc_tx = {adc_nib, adc_val[adc_last_ch]};
            MISO = adc_tx[15];
            adc_bits = 0;
            adc_rx = '0;
        end else if (SS_n === 1'b0 && sclk_prev === 1'b0 && SCLK === 1'b1) begin
            adc_rx = {adc_rx[14:0], MOSI};
            adc_bits++;
            if (adc_bits == 16) begin
                adc_last_ch = adc_rx[13:11];
                mosi_words.push_back(adc_rx);
            end
        end else if (SS_n === 1'b0 && sclk_prev === 1'b1 && SCLK === 1'b0) begin
            adc_tx = {adc_tx[14:0], 1'b0};
            MISO = adc_tx[15];
        end
        ss_prev = SS_n;
        sclk_prev = SCLK;
    end

    // Expected pot contents.
    logic [11:0] exp_pot [6];
    bit          primed [6];
    int          exp_ch;

    task automatic model_reset();
        for (int c = 0; c < 6; c++) begin
            exp_pot[c] = 12'h000;
            primed[c] = 1'b0;
        end
        exp_ch = 0;
    endtask

    task automatic model_update(input int c, input logic [11:0] v);
`ifdef POT_FILTER_EN
        if (primed[c]) exp_pot[c] = 12'((int'(exp_pot[c]) + int'(v) + 1) / 2);
        else exp_pot[c] = v;
`else
        exp_pot[c] = v;
`endif
        primed[c] = 1'b1;
    endtask

    function automatic logic [11:0] port_val(input int c);
        case (c)
            0: return lp_pot;
            1: return b1_pot;
            2: return b2_pot;
            3: return b3_pot;
            4: return hp_pot;
            default: return volume;
        endcase
    endfunction

    task automatic hold_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_reset();
        rst = 1'b0;
        model_reset();
        mosi_words.delete();
    endtask

    task automatic wait_upd(input int budget, output int cycles, output bit timed_out);
        cycles = 0;
        timed_out = 1'b1;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (pot_upd === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        hold_reset();
        compared++; if (SS_n !== 1'b1) begin mismatched++; $display("FAIL reset_ss_n: got %b want 1", SS_n); end
        compared++; if (SCLK !== 1'b0) begin mismatched++; $display("FAIL reset_sclk: got %b want 0", SCLK); end
        compared++; if (MOSI !== 1'b0) begin mismatched++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
        compared++; if (pot_upd !== 1'b0) begin mismatched++; $display("FAIL reset_pot_upd: got %b want 0", pot_upd); end
        compared++; if (pot_ch !== 3'd0) begin mismatched++; $display("FAIL reset_pot_ch: got %0d want 0", pot_ch); end
        for (int c = 0; c < 6; c++) begin
            compared++;
            if (port_val(c) !== 12'h000) begin mismatched++; $display("FAIL reset_pot%0d: got %h want 000", c, port_val(c)); end
        end
    endtask

    task automatic test_first_update();
        int cyc; bit to;
        hold_reset();
        adc_nib = 4'($urandom);
        for (int c = 0; c < 6; c++) adc_val[c] = 12'h0A5 + 12'(c);
        release_reset();
        wait_upd(3 * FRAME, cyc, to);
        compared++; if (to || cyc != 2 * FRAME) begin mismatched++; $display("FAIL first_upd_time: got %0d clks (timeout=%0d) want %0d", cyc, to, 2 * FRAME); end
        compared++; if (pot_ch !== 3'd0) begin mismatched++; $display("FAIL first_upd_ch: got %0d want 0", pot_ch); end
        compared++; if (lp_pot !== 12'h0A5) begin mismatched++; $display("FAIL first_upd_lp: got %h want 0a5", lp_pot); end
        compared++; if (b1_pot !== 12'h000) begin mismatched++; $display("FAIL first_upd_b1_idle: got %h want 000", b1_pot); end
    endtask

    task automatic test_rotation();
        int cyc; bit to;
        logic [15:0] w;
        hold_reset();
        adc_nib = 4'($urandom);
        for (int c = 0; c < 6; c++) adc_val[c] = 12'($urandom_range(1, 4095));
        release_reset();
        for (int k = 0; k < 13; k++) begin
            wait_upd(3 * FRAME, cyc, to);
            compared++;
            if (to || cyc != ((k == 0) ? 2 * FRAME : FRAME)) begin
                mismatched++;
                $display("FAIL rot_spacing[%0d]: got %0d clks (timeout=%0d) want %0d", k, cyc, to, (k == 0) ? 2 * FRAME : FRAME);
                if (to) return;
            end
            compared++; if (pot_ch !== 3'(exp_ch)) begin mismatched++; $display("FAIL rot_ch[%0d]: got %0d want %0d", k, pot_ch, exp_ch); end
            model_update(exp_ch, adc_val[exp_ch]);
            for (int c = 0; c < 6; c++) begin
                compared++;
                if (port_val(c) !== exp_pot[c]) begin mismatched++; $display("FAIL rot_pot[%0d] ch%0d: got %h want %h", k, c, port_val(c), exp_pot[c]); end
            end
            exp_ch = (exp_ch + 1) % 6;
        end
        compared++; if (mosi_words.size() < 14) begin mismatched++; $display("FAIL rot_mosi_count: got %0d want 14", mosi_words.size()); end
        for (int i = 0; i < 14 && i < mosi_words.size(); i++) begin
            w = '0;
            w[13:11] = 3'(i % 6);
            compared++;
            if (mosi_words[i] !== w) begin mismatched++; $display("FAIL rot_mosi[%0d]: got %h want %h", i, mosi_words[i], w); end
        end
    endtask

    task automatic test_sclk_timing();
        int n = 0, win = 0, rises = 0, lead = 0, hi = 0, lo = 0, bad_hi = 0, bad_lo = 0, g = 0;
        bit prev = 1'b0;
        while (SS_n !== 1'b1 && n < 2 * FRAME) begin @(negedge clk); n++; end
        while (SS_n !== 1'b0 && n < 2 * FRAME) begin @(negedge clk); n++; end
        compared++;
        if (n >= 2 * FRAME) begin mismatched++; $display("FAIL sclk_frame_start: got no SS_n fall within %0d clks", 2 * FRAME); return; end
        while (SS_n === 1'b0 && win < 2 * FRAME) begin
            win++;
            if (SCLK === 1'b1) begin
                if (!prev) begin
                    rises++;
                    if (rises > 1 && lo != SH) bad_lo++;
                    lo = 0;
                end
                hi++;
            end else begin
                if (prev) begin
                    if (hi != SH) bad_hi++;
                    hi = 0;
                end
                if (rises == 0) lead++;
                else lo++;
            end
            prev = SCLK;
            @(negedge clk);
        end
        while (SS_n === 1'b1 && g < 2 * FRAME) begin g++; @(negedge clk); end
        compared++; if (win != 34 * SH) begin mismatched++; $display("FAIL sclk_window: got %0d clks want %0d", win, 34 * SH); end
        compared++; if (rises != 16) begin mismatched++; $display("FAIL sclk_rises: got %0d want 16", rises); end
        compared++; if (lead != 2 * SH) begin mismatched++; $display("FAIL sclk_lead_low: got %0d want %0d", lead, 2 * SH); end
        compared++; if (bad_hi != 0) begin mismatched++; $display("FAIL sclk_high_len: got %0d bad periods want 0", bad_hi); end
        compared++; if (bad_lo != 0) begin mismatched++; $display("FAIL sclk_low_len: got %0d bad periods want 0", bad_lo); end
        compared++; if (lo != SH) begin mismatched++; $display("FAIL sclk_back_porch: got %0d want %0d", lo, SH); end
        compared++; if (g != GAP) begin mismatched++; $display("FAIL ss_gap: got %0d want %0d", g, GAP); end
    endtask

    task automatic test_midframe_reset();
        int n = 0, rises = 0, cyc;
        bit prev = 1'b0, to;
        while (SS_n !== 1'b1 && n < 2 * FRAME) begin @(negedge clk); n++; end
        while (SS_n !== 1'b0 && n < 2 * FRAME) begin @(negedge clk); n++; end
        while (rises < 7 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
            if (SCLK === 1'b1 && !prev) rises++;
            prev = SCLK;
        end
        compared++;
        if (rises != 7) begin mismatched++; $display("FAIL mid_rst_setup: got %0d rises want 7", rises); return; end
        rst = 1'b1;
        @(negedge clk);
        compared++; if (SS_n !== 1'b1) begin mismatched++; $display("FAIL mid_rst_ss_n: got %b want 1", SS_n); end
        compared++; if (SCLK !== 1'b0) begin mismatched++; $display("FAIL mid_rst_sclk: got %b want 0", SCLK); end
        compared++; if (MOSI !== 1'b0) begin mismatched++; $display("FAIL mid_rst_mosi: got %b want 0", MOSI); end
        for (int c = 0; c < 6; c++) begin
            compared++;
            if (port_val(c) !== 12'h000) begin mismatched++; $display("FAIL mid_rst_pot%0d: got %h want 000", c, port_val(c)); end
        end
        release_reset();
        wait_upd(3 * FRAME, cyc, to);
        compared++; if (to || cyc != 2 * FRAME) begin mismatched++; $display("FAIL mid_rst_upd_time: got %0d clks (timeout=%0d) want %0d", cyc, to, 2 * FRAME); end
        compared++; if (pot_ch !== 3'd0) begin mismatched++; $display("FAIL mid_rst_upd_ch: got %0d want 0", pot_ch); end
        compared++; if (lp_pot !== adc_val[0]) begin mismatched++; $display("FAIL mid_rst_upd_lp: got %h want %h", lp_pot, adc_val[0]); end
    endtask

    task automatic test_boundary();
        int cyc; bit to;
        hold_reset();
        adc_nib = 4'hF;
        for (int c = 0; c < 6; c++) adc_val[c] = 12'($urandom);
        adc_val[0] = 12'hFFF;
        adc_val[1] = 12'h000;
        release_reset();
        wait_upd(3 * FRAME, cyc, to);
        compared++; if (to || pot_ch !== 3'd0 || lp_pot !== 12'hFFF) begin mismatched++; $display("FAIL bound_fff: got ch %0d lp %h (timeout=%0d) want ch 0 lp fff", pot_ch, lp_pot, to); end
        wait_upd(3 * FRAME, cyc, to);
        compared++; if (to || pot_ch !== 3'd1 || b1_pot !== 12'h000) begin mismatched++; $display("FAIL bound_000: got ch %0d b1 %h (timeout=%0d) want ch 1 b1 000", pot_ch, b1_pot, to); end
    endtask

    task automatic test_filter();
        int cyc; bit to;
        logic [11:0] want_lp;
        hold_reset();
        adc_nib = 4'($urandom);
        for (int c = 0; c < 6; c++) adc_val[c] = 12'($urandom);
        adc_val[0] = 12'h000;
        release_reset();
        wait_upd(3 * FRAME, cyc, to);
        compared++; if (to || pot_ch !== 3'd0 || lp_pot !== 12'h000) begin mismatched++; $display("FAIL filt_first: got ch %0d lp %h (timeout=%0d) want ch 0 lp 000", pot_ch, lp_pot, to); end
        model_update(0, 12'h000);
        exp_ch = 1;
        adc_val[0] = 12'hFFF;
        for (int k = 0; k < 6; k++) begin
            wait_upd(3 * FRAME, cyc, to);
            compared++;
            if (to || pot_ch !== 3'(exp_ch)) begin mismatched++; $display("FAIL filt_ch[%0d]: got %0d (timeout=%0d) want %0d", k, pot_ch, to, exp_ch); if (to) return; end
            model_update(exp_ch, adc_val[exp_ch]);
            compared++;
            if (port_val(exp_ch) !== exp_pot[exp_ch]) begin mismatched++; $display("FAIL filt_pot[%0d]: got %h want %h", k, port_val(exp_ch), exp_pot[exp_ch]); end
            exp_ch = (exp_ch + 1) % 6;
        end
`ifdef POT_FILTER_EN
        want_lp = 12'h800;
`else
        want_lp = 12'hFFF;
`endif
        compared++; if (lp_pot !== want_lp) begin mismatched++; $display("FAIL filt_lp_second: got %h want %h", lp_pot, want_lp); end
    endtask

    initial begin
        for (int c = 0; c < 6; c++) adc_val[c] = 12'h000;
        model_reset();
        test_reset();
        test_first_update();
        test_rotation();
        test_sclk_timing();
        test_midframe_reset();
        test_boundary();
        test_filter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
